// File: rtl/aes_pkg.sv
// aes_pkg: shared FSM states, column count and byte-position helper for the AES sub/shift path
package aes_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, SUB = 2'd1, HOLD = 2'd2} state_t;
    localparam int NUM_COLS = 4;
    // lsb of byte s[r][c] (byte 4c+r) inside a 128-bit state, byte 0 in the top bits
    function automatic int byte_off(input int r, input int c);
        return 120 - 8 * (4 * c + r);
    endfunction
endpackage

// File: rtl/aes_shiftrows_128.sv
// aes_shiftrows_128: combinational ShiftRows (enc_dec=1) or InvShiftRows (enc_dec=0)
module aes_shiftrows_128
    import aes_pkg::*;
(
    input  logic [127:0] state,
    input  logic         enc_dec,
    output logic [127:0] shifted
);
    for (genvar r = 0; r < 4; r++) begin : g_row
        for (genvar c = 0; c < NUM_COLS; c++) begin : g_col
            assign shifted[byte_off(r, c) +: 8] = enc_dec ? state[byte_off(r, (c + r) % NUM_COLS) +: 8]
                                                          : state[byte_off(r, (c + NUM_COLS - r) % NUM_COLS) +: 8];
        end
    end
endmodule

// File: rtl/aes_sub_shift_sequencer.sv
// aes_sub_shift_sequencer: streams a state column by column through an external S-box, then row-shifts it
module aes_sub_shift_sequencer
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    input  logic         in_enc_dec,
    output logic [31:0]  sb_data_out,
    output logic         sb_enc_dec,
    input  logic [31:0]  sb_data_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);
    state_t       state;
    logic [1:0]   col;
    logic [127:0] in_q;
    logic [127:0] res;
    logic [127:0] res_next;
    logic [127:0] shifted;
    logic [127:0] out_q;
    logic         mode_q;

    assign in_ready    = state == IDLE;
    assign busy        = state != IDLE;
    assign out_valid   = state == HOLD;
    assign out_state   = out_q;
    assign sb_enc_dec  = mode_q;
    assign sb_data_out = (state == SUB) ? in_q[{~col, 5'd0} +: 32] : 32'd0;

    // result with the current column's substitution merged in, so the last column reaches the shifter directly
    always_comb begin
        res_next = res;
        res_next[{~col, 5'd0} +: 32] = sb_data_in;
    end

    aes_shiftrows_128 u_shift (
        .state   (res_next),
        .enc_dec (mode_q),
        .shifted (shifted)
    );

    // accept, substitute one column per cycle, then hold the shifted result until taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            col    <= 2'd0;
            in_q   <= '0;
            res    <= '0;
            out_q  <= '0;
            mode_q <= 1'b1;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    in_q   <= in_state;
                    mode_q <= in_enc_dec;
                    col    <= 2'd0;
                    state  <= SUB;
                end
                SUB: begin
                    res <= res_next;
                    col <= col + 2'd1;
                    if (col == 2'(NUM_COLS - 1)) begin
                        out_q <= shifted;
                        state <= HOLD;
                    end
                end
                HOLD: if (out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
